priority_enc_arb: RTL and testbench

PRIORITY_ENC_ARB -- requirements
Module: priority_enc_arb

---
 rtl/pri_enc_pkg.sv | 7 +
 rtl/pri_find_first.sv | 33 +++
 rtl/priority_enc_arb.sv | 80 ++++++++
 tb/tb_priority_enc_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_pkg.sv
// Shared constants for the priority encoder / arbiter slice.
package pri_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pri_find_first.sv
// Rotating find-first-set: returns the first set bit of vec scanning from
// start upward, wrapping past N-1 back to 0.
module pri_find_first #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  int         w_pos;
  logic [W-1:0] w_pos_w;

  // Scan from the far end so the closest position to start is written last.
  always_comb begin
    idx     = '0;
    found   = 1'b0;
    w_pos   = 0;
    w_pos_w = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = int'(start) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_pos_w = W'(w_pos);
      if (vec[w_pos_w]) begin
        idx   = w_pos_w;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_enc_arb.sv
// Registered priority encoder with fixed or round-robin grant selection and
// a valid/ready output handshake.
module priority_enc_arb
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_none,
  input  logic         out_ready
);

  logic [W-1:0] r_ptr;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_none;

  logic [W-1:0] w_start;
  logic [W-1:0] w_idx;
  logic         w_found;
  logic         w_accept;
  logic [N-1:0] w_onehot;

  // Fixed priority is a rotating search anchored at bit 0.
  assign w_start  = (mode == MODE_RR) ? r_ptr : '0;
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  pri_find_first #(.N(N), .W(W)) u_find (
    .vec   (in_req),
    .start (w_start),
    .idx   (w_idx),
    .found (w_found)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_onehot[i] = w_found && (w_idx == W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_idx    <= w_found ? w_idx : '0;
        r_onehot <= w_onehot;
        r_none   <= !w_found;
        if ((mode == MODE_RR) && w_found) begin
          r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_none   = r_none;

endmodule

// File: tb/tb_priority_enc_arb.sv
// Scoreboard bench for priority_enc_arb at N=8.
module tb_priority_enc_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_req = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_none;
  logic         out_ready = 1'b0;

  priority_enc_arb #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_req     (in_req),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] idx;
    logic [N-1:0] oh;
    logic         none;
  } exp_t;

  exp_t sb[$];
  int   m_ptr = 0;
  logic m_valid = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference: fixed = lowest set bit; round-robin = lowest set bit at or
  // above ptr, else lowest set bit below ptr.
  function automatic exp_t model(input logic [N-1:0] req, input logic md, input int ptr);
    exp_t e;
    e.idx = '0; e.oh = '0; e.none = 1'b1;
    if (md == 1'b0) begin
      for (int i = N - 1; i >= 0; i--)
        if (req[i]) begin e.idx = W'(i); e.none = 1'b0; end
    end else begin
      for (int i = ptr - 1; i >= 0; i--)
        if (req[i]) begin e.idx = W'(i); e.none = 1'b0; end
      for (int i = N - 1; i >= ptr; i--)
        if (req[i]) begin e.idx = W'(i); e.none = 1'b0; end
    end
    if (!e.none) e.oh = N'(1) << e.idx;
    return e;
  endfunction

  // One cycle starting at a falling edge: drive, check, update model, advance.
  task automatic xfer(input logic md, input logic [N-1:0] req, input logic vld, input logic ordy);
    exp_t e;
    logic acc;
    mode = md; in_req = req; in_valid = vld; out_ready = ordy;
    #1;
    n_total++;
    if (in_ready !== (!m_valid || ordy))
      $display("FAIL in_ready: got %b want %b", in_ready, (!m_valid || ordy));
    else n_pass++;
    n_total++;
    if (out_valid !== m_valid)
      $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
    else n_pass++;
    if (m_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard: got result with no expectation queued, want entry");
      end else begin
        e = ordy ? sb.pop_front() : sb[0];
        if ({out_idx, out_onehot, out_none} !== {e.idx, e.oh, e.none})
          $display("FAIL result: got idx=%0d oh=%b none=%b want idx=%0d oh=%b none=%b",
                   out_idx, out_onehot, out_none, e.idx, e.oh, e.none);
        else n_pass++;
      end
    end
    acc = vld && (!m_valid || ordy);
    if (acc) begin
      e = model(req, md, m_ptr);
      sb.push_back(e);
      if (md && !e.none) m_ptr = (int'(e.idx) + 1) % N;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++;
    if ({out_valid, out_idx, out_onehot, out_none} !== '0)
      $display("FAIL reset_outputs: got v=%b idx=%0d oh=%b none=%b want all 0",
               out_valid, out_idx, out_onehot, out_none);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_total++;
    if (dut.r_ptr !== 3'd0) $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_fixed();
    xfer(1'b0, 8'b1010_0100, 1'b1, 1'b1);
    n_total++;
    #0;
    if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_onehot !== 8'b0000_0100 || out_none !== 1'b0)
      $display("FAIL fixed_a4: got v=%b idx=%0d oh=%b none=%b want 1/2/00000100/0",
               out_valid, out_idx, out_onehot, out_none);
    else n_pass++;
    xfer(1'b0, 8'h80, 1'b1, 1'b1);
    xfer(1'b0, 8'hFF, 1'b1, 1'b1);
    xfer(1'b0, 8'h48, 1'b1, 1'b1);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_rr_sweep();
    int want_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    xfer(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      n_total++;
      if (out_idx !== W'(want_seq[i-1]))
        $display("FAIL rr_sweep[%0d]: got %0d want %0d", i - 1, out_idx, want_seq[i-1]);
      else n_pass++;
      if (i < 9) xfer(1'b1, 8'hFF, 1'b1, 1'b1);
      else       xfer(1'b1, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    xfer(1'b1, 8'b0010_0000, 1'b1, 1'b1);
    xfer(1'b1, 8'b0000_0011, 1'b1, 1'b1);
    n_total++;
    if (out_idx !== 3'd0) $display("FAIL wrap_first: got %0d want 0", out_idx);
    else n_pass++;
    xfer(1'b1, 8'b0000_0011, 1'b1, 1'b1);
    n_total++;
    if (out_idx !== 3'd1) $display("FAIL wrap_second: got %0d want 1", out_idx);
    else n_pass++;
    xfer(1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_none();
    xfer(1'b1, 8'h00, 1'b1, 1'b1);
    n_total++;
    if (out_none !== 1'b1 || out_idx !== 3'd0 || out_onehot !== 8'h00 || out_valid !== 1'b1)
      $display("FAIL none: got v=%b none=%b idx=%0d oh=%b want 1/1/0/0",
               out_valid, out_none, out_idx, out_onehot);
    else n_pass++;
    xfer(1'b1, 8'hFF, 1'b1, 1'b1);
    n_total++;
    if (out_idx !== 3'd2) $display("FAIL none_ptr_kept: got %0d want 2", out_idx);
    else n_pass++;
    xfer(1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    xfer(1'b1, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'hF0, 1'b1, 1'b0);
    xfer(1'b1, 8'hF0, 1'b1, 1'b1);
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 8'hFF, 1'b1, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, out_idx, out_onehot, out_none} !== '0)
      $display("FAIL mid_reset_outputs: got v=%b idx=%0d oh=%b none=%b want all 0",
               out_valid, out_idx, out_onehot, out_none);
    else n_pass++;
    n_total++;
    if (dut.r_ptr !== 3'd0) $display("FAIL mid_reset_ptr: got %0d want 0", dut.r_ptr);
    else n_pass++;
    #1 rst = 1'b0;
    sb.delete();
    m_valid = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    xfer(1'b1, 8'hFF, 1'b1, 1'b1);
    n_total++;
    if (out_idx !== 3'd0) $display("FAIL after_reset_rr: got %0d want 0", out_idx);
    else n_pass++;
    xfer(1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      xfer(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0));
    end
    xfer(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_fixed();
    test_rr_sweep();
    test_wrap();
    test_none();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
